// File: rtl/vh_unpack_pkg.sv
// Shared layout helpers for the vloghammer result-bus unpacker.
// Field k spans field_width(k) bits ending at field_msb(k) inside the 90-bit vector.
package vh_unpack_pkg;

    localparam int NUM_FIELDS = 18;
    localparam int VEC_W      = 90;
    localparam int IDX_W      = 5;
    localparam int MAX_FW     = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int field_width(input int k);
        return 4 + (k % 3);
    endfunction

    // Each group of three fields (4+5+6 bits) occupies 15 bits, packed from the top down.
    function automatic int field_msb(input int k);
        int off;
        case (k % 3)
            0:       off = 0;
            1:       off = 4;
            default: off = 9;
        endcase
        return (VEC_W - 1) - 15 * (k / 3) - off;
    endfunction

    function automatic logic field_is_signed(input int k);
        return ((k / 3) % 2) == 1;
    endfunction

endpackage

// File: rtl/vh_field_extract.sv
// Combinational field selector: picks field idx out of the held vector and extends it.
// Parity output exists only when VH_UNPACK_PARITY_EN is defined.
module vh_field_extract
    import vh_unpack_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [VEC_W-1:0] hold,
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] field,
    output logic             is_signed
`ifdef VH_UNPACK_PARITY_EN
    ,
    output logic             par
`endif
);

    logic [MAX_FW-1:0] raw;
    logic              sign_bit;
    int                k;
    int                w;
    int                lsb;

    always_comb begin
        k         = int'(idx);
        w         = field_width(k);
        lsb       = field_msb(k) - w + 1;
        raw       = '0;
        for (int i = 0; i < MAX_FW; i++) begin
            if (i < w) begin
                raw[i] = hold[lsb + i];
            end
        end
        is_signed = field_is_signed(k);
        sign_bit  = is_signed & raw[w - 1];
        // Fill with the extension bit first, then overlay the raw field bits.
        field     = {OUT_W{sign_bit}};
        for (int i = 0; i < MAX_FW; i++) begin
            if (i < w) begin
                field[i] = raw[i];
            end
        end
    end

`ifdef VH_UNPACK_PARITY_EN
    assign par = ^raw;
`endif

endmodule

// File: rtl/vh_result_unpacker.sv
// Streams the 18 fields of a vloghammer result vector and emits a rotate-XOR signature.
// Define VH_UNPACK_PARITY_EN to add out_par and fold field parity into the signature MSB.
module vh_result_unpacker
    import vh_unpack_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int SIG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [OUT_W-1:0] out_field,
    output logic             out_signed,
    output logic             out_last,
`ifdef VH_UNPACK_PARITY_EN
    output logic             out_par,
`endif
    output logic             sig_valid,
    output logic [SIG_W-1:0] sig_data
);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [VEC_W-1:0] hold;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] sig_step;
    logic [OUT_W-1:0] ext_field;
    logic             ext_signed;
    logic             beat;
    logic             last;
`ifdef VH_UNPACK_PARITY_EN
    logic             ext_par;
`endif

    vh_field_extract #(
        .OUT_W(OUT_W)
    ) u_extract (
        .hold      (hold),
        .idx       (idx),
        .field     (ext_field),
        .is_signed (ext_signed)
`ifdef VH_UNPACK_PARITY_EN
        ,
        .par       (ext_par)
`endif
    );

    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        out_valid  = (state == STREAM);
        last       = (idx == IDX_W'(NUM_FIELDS - 1));
        beat       = out_valid & out_ready;
        // Presented outputs are forced to zero outside STREAM so IDLE looks like reset.
        out_idx    = out_valid ? idx : '0;
        out_field  = out_valid ? ext_field : '0;
        out_signed = out_valid & ext_signed;
        out_last   = out_valid & last;
`ifdef VH_UNPACK_PARITY_EN
        out_par    = out_valid & ext_par;
        sig_step   = {sig[SIG_W-2:0], sig[SIG_W-1]} ^ SIG_W'(ext_field)
                     ^ {ext_par, {(SIG_W-1){1'b0}}};
`else
        sig_step   = {sig[SIG_W-2:0], sig[SIG_W-1]} ^ SIG_W'(ext_field);
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (beat && last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            hold      <= '0;
            sig       <= '0;
            sig_valid <= 1'b0;
            sig_data  <= '0;
        end else begin
            state     <= state_next;
            sig_valid <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    hold <= in_data;
                    idx  <= '0;
                    sig  <= '0;
                end
            end else if (beat) begin
                sig <= sig_step;
                if (last) begin
                    idx       <= '0;
                    sig_valid <= 1'b1;
                    sig_data  <= sig_step;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vh_result_unpacker.sv
// Self-checking bench for vh_result_unpacker: directed vector table plus corner sequences.
// Field model walks the packed layout bit by bit; honours VH_UNPACK_PARITY_EN.
module tb_vh_result_unpacker;

    localparam int OUT_W = 8;
    localparam int SIG_W = 32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [7:0]  out_field;
    logic        out_signed;
    logic        out_last;
`ifdef VH_UNPACK_PARITY_EN
    logic        out_par;
`endif
    logic        sig_valid;
    logic [31:0] sig_data;

    int vecCount = 0;
    int errCount = 0;

    vh_result_unpacker #(
        .OUT_W(OUT_W),
        .SIG_W(SIG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_field  (out_field),
        .out_signed (out_signed),
        .out_last   (out_last),
`ifdef VH_UNPACK_PARITY_EN
        .out_par    (out_par),
`endif
        .sig_valid  (sig_valid),
        .sig_data   (sig_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [89:0] data;
        int          chkIdx;
        logic [7:0]  expField;
        logic        expSigned;
        logic        sigKnown;
        logic [31:0] expSig;
    } vec_t;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Field positions are derived by walking widths down from bit 89, not from a table.
    function automatic void modelField(input logic [89:0] vec, input int k,
                                       output logic [7:0] f, output logic s, output logic p);
        int pos;
        int w;
        logic sb;
        pos = 89;
        for (int j = 0; j < k; j++) pos -= 4 + (j % 3);
        w = 4 + (k % 3);
        s = ((k / 3) % 2) == 1;
        p = 1'b0;
        f = '0;
        for (int b = 0; b < w; b++) begin
            f[b] = vec[pos - w + 1 + b];
            p    = p ^ vec[pos - w + 1 + b];
        end
        sb = s & vec[pos];
        for (int b = w; b < 8; b++) f[b] = sb;
    endfunction

    function automatic logic [31:0] modelSig(input logic [89:0] vec);
        logic [31:0] sg;
        logic [7:0]  f;
        logic        s;
        logic        p;
        sg = '0;
        for (int k = 0; k < 18; k++) begin
            modelField(vec, k, f, s, p);
            sg = {sg[30:0], sg[31]} ^ {24'h0, f};
`ifdef VH_UNPACK_PARITY_EN
            sg = sg ^ {p, 31'h0};
`endif
        end
        return sg;
    endfunction

    task automatic beatCheck(input logic [89:0] vec, input int k);
        logic [7:0] f;
        logic       s;
        logic       p;
        modelField(vec, k, f, s, p);
        checkOutput($sformatf("idx%0d out_valid", k), out_valid, 1);
        checkOutput($sformatf("idx%0d out_idx", k), out_idx, k);
        checkOutput($sformatf("idx%0d out_field", k), out_field, f);
        checkOutput($sformatf("idx%0d out_signed", k), out_signed, s);
        checkOutput($sformatf("idx%0d out_last", k), out_last, (k == 17));
        checkOutput($sformatf("idx%0d in_ready", k), in_ready, 0);
        checkOutput($sformatf("idx%0d sig_valid", k), sig_valid, 0);
`ifdef VH_UNPACK_PARITY_EN
        checkOutput($sformatf("idx%0d out_par", k), out_par, p);
`endif
    endtask

    task automatic applyStimulus(input logic [89:0] vec);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("in_ready before accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = vec;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called one step after acceptance; ends in the cycle sig_valid must be high.
    task automatic streamVector(input logic [89:0] vec, input int stallAt, input int stallLen,
                                input logic [89:0] noise, input int chkIdx,
                                input logic [7:0] expField, input logic expSigned);
        for (int k = 0; k < 18; k++) begin
            if (k == stallAt) begin
                out_ready = 1'b0;
                for (int s = 0; s < stallLen; s++) begin
                    beatCheck(vec, k);
                    in_valid = (s % 2) == 0;
                    in_data  = noise;
                    @(posedge clk); #1;
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            beatCheck(vec, k);
            if (k == chkIdx) begin
                checkOutput($sformatf("hand idx%0d field", k), out_field, expField);
                checkOutput($sformatf("hand idx%0d signed", k), out_signed, expSigned);
            end
            @(posedge clk); #1;
        end
        checkOutput("sig_valid at end", sig_valid, 1);
        checkOutput("sig_data model", sig_data, modelSig(vec));
        checkOutput("out_valid after last", out_valid, 0);
        checkOutput("in_ready after last", in_ready, 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " in_ready"}, in_ready, 1);
        checkOutput({tag, " out_valid"}, out_valid, 0);
        checkOutput({tag, " out_idx"}, out_idx, 0);
        checkOutput({tag, " out_field"}, out_field, 0);
        checkOutput({tag, " out_signed"}, out_signed, 0);
        checkOutput({tag, " out_last"}, out_last, 0);
        checkOutput({tag, " sig_valid"}, sig_valid, 0);
        checkOutput({tag, " sig_data"}, sig_data, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        tbl[6];
        logic [89:0] vecA;
        logic [89:0] vecB;
        logic [31:0] held;

        tbl[0] = '{90'hA << 86, 0, 8'h0A, 1'b0, 1'b1, 32'h0014_0000};
        tbl[1] = '{90'h8 << 71, 3, 8'hF8, 1'b1, 1'b1, 32'h003E_0000};
        tbl[2] = '{90'h1F << 60, 5, 8'h1F, 1'b1, 1'b1, 32'h0001_F000};
        tbl[3] = '{90'h1, 17, 8'h01, 1'b1, 1'b1, 32'h0000_0001};
        tbl[4] = '{90'h0, 10, 8'h00, 1'b1, 1'b1, 32'h0000_0000};
        tbl[5] = '{~90'h0, 2, 8'h3F, 1'b0, 1'b0, 32'h0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].data);
            streamVector(tbl[i].data, -1, 0, '0, tbl[i].chkIdx, tbl[i].expField, tbl[i].expSigned);
`ifndef VH_UNPACK_PARITY_EN
            if (tbl[i].sigKnown)
                checkOutput($sformatf("vec%0d hand sig", i), sig_data, tbl[i].expSig);
`endif
            held = sig_data;
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d sig pulse width", i), sig_valid, 0);
            checkOutput($sformatf("vec%0d sig_data hold", i), sig_data, modelSig(tbl[i].data));
        end

        // Backpressure at idx 7 for 5 cycles, with in_valid noise that must be ignored.
        vecA = {$urandom, $urandom, $urandom};
        applyStimulus(vecA);
        streamVector(vecA, 7, 5, {$urandom, $urandom, $urandom}, -1, 8'h0, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset while idx 9 is presented.
        vecA = {$urandom, $urandom, $urandom};
        applyStimulus(vecA);
        for (int k = 0; k < 9; k++) begin
            beatCheck(vecA, k);
            @(posedge clk); #1;
        end
        checkOutput("pre-reset idx", out_idx, 9);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput("post-reset sig_valid", sig_valid, 0);
            checkOutput("post-reset out_valid", out_valid, 0);
        end
        vecB = {$urandom, $urandom, $urandom};
        applyStimulus(vecB);
        streamVector(vecB, -1, 0, '0, -1, 8'h0, 1'b0);
        @(posedge clk); #1;

        // Back-to-back: in_valid held high, second vector taken in the sig_valid cycle.
        vecA = 90'h2AB_CDEF_0123_4567_89AB_CDEF;
        vecB = 90'h154_3210_FEDC_BA98_7654_3210;
        in_valid = 1'b1;
        in_data  = vecA;
        @(posedge clk); #1;
        in_data = vecB;
        for (int k = 0; k < 18; k++) begin
            beatCheck(vecA, k);
            @(posedge clk); #1;
        end
        checkOutput("b2b sig_valid A", sig_valid, 1);
        checkOutput("b2b in_ready with sig_valid", in_ready, 1);
        checkOutput("b2b sig_data A", sig_data, modelSig(vecA));
        @(posedge clk); #1;
        in_valid = 1'b0;
        streamVector(vecB, -1, 0, '0, -1, 8'h0, 1'b0);
        checkOutput("b2b sig_data B", sig_data, modelSig(vecB));
        @(posedge clk); #1;
        checkOutput("final sig_valid low", sig_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
